// File: rtl/lfo_phase_gen.sv
// LFO phase accumulator with quadrant fold to a CORDIC-ready angle and a matched sign/valid delay line.
// Optional build macro: LFO_ZERO_ANGLE_GUARD_EN (maps folded angle 0 to 16'h0001).
module lfo_phase_gen #(
    parameter logic [15:0] INC_RESET = 16'h0000,
    parameter int          DELAY     = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        sync,
    input  logic [15:0] inc_in,
    input  logic        inc_load,
    output logic [15:0] angle,
    output logic        angle_valid,
    output logic        cos_neg,
    output logic        cos_neg_dly,
    output logic        valid_dly
);
    localparam logic [24:0] WRAP = 25'd11796480;

    logic [23:0]        r_acc;
    logic [15:0]        r_inc;
    logic [15:0]        r_shadow;
    logic               r_pend;
    logic [DELAY-1:0]   r_vld_pipe;
    logic [DELAY-1:0]   r_cn_pipe;

    logic [15:0]        w_inc;
    logic [24:0]        w_sum;
    logic [23:0]        w_acc_nxt;
    logic signed [16:0] w_p;
    logic signed [16:0] w_fold;
    logic               w_fold_neg;
    logic [15:0]        w_angle;

    // A load seen on an earlier edge is already the step increment; one on the tick edge waits.
    assign w_inc     = r_pend ? r_shadow : r_inc;
    assign w_sum     = {1'b0, r_acc} + {9'd0, w_inc};
    assign w_acc_nxt = (w_sum >= WRAP) ? 24'(w_sum - WRAP) : w_sum[23:0];
    assign w_p       = {1'b0, w_acc_nxt[23:8]};

    always_comb begin
        w_fold     = w_p;
        w_fold_neg = 1'b0;
        if (w_p >= 17'sd34560) begin
            w_fold = w_p - 17'sd46080;
        end else if (w_p >= 17'sd11520) begin
            w_fold     = 17'sd23040 - w_p;
            w_fold_neg = 1'b1;
        end
    end

`ifdef LFO_ZERO_ANGLE_GUARD_EN
    assign w_angle = (w_fold == 17'sd0) ? 16'h0001 : 16'(w_fold);
`else
    assign w_angle = 16'(w_fold);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_inc       <= INC_RESET;
            r_shadow    <= INC_RESET;
            r_pend      <= 1'b0;
            angle       <= '0;
            angle_valid <= 1'b0;
            cos_neg     <= 1'b0;
        end else begin
            angle_valid <= tick & ~sync;
            if (sync) begin
                r_acc <= '0;
            end else if (tick) begin
                r_acc   <= w_acc_nxt;
                angle   <= w_angle;
                cos_neg <= w_fold_neg;
            end
            if (tick)
                r_inc <= w_inc;
            if (inc_load) begin
                r_shadow <= inc_in;
                r_pend   <= 1'b1;
            end else if (tick) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_cn_pipe  <= '0;
        end else begin
            r_vld_pipe[0] <= angle_valid;
            r_cn_pipe[0]  <= cos_neg;
            for (int i = 1; i < DELAY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_cn_pipe[i]  <= r_cn_pipe[i-1];
            end
        end
    end

    assign valid_dly   = r_vld_pipe[DELAY-1];
    assign cos_neg_dly = r_cn_pipe[DELAY-1];
endmodule

// File: doc/lfo_phase_gen.md
LFO_PHASE_GEN -- requirements
Module: lfo_phase_gen

Interface
REQ-001 Parameter INC_RESET, default 16'h0000, phase increment loaded at reset.
REQ-002 Parameter DELAY, default 9, latency of the downstream CORDIC stage in clk cycles (range 1..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 tick  input  1  sample strobe; one phase step per high cycle.
REQ-006 sync  input  1  phase restart pulse.
REQ-007 inc_in  input  16  unsigned phase increment, units 1/32768 degree per tick.
REQ-008 inc_load  input  1  pulse; capture inc_in as new increment.
REQ-009 angle  output  16  signed folded angle to CORDIC, units 1/128 degree, range -11520..+11520.
REQ-010 angle_valid  output  1  one-cycle pulse, angle updated.
REQ-011 cos_neg  output  1  cosine sign-correction flag aligned with angle.
REQ-012 cos_neg_dly  output  1  cos_neg delayed DELAY cycles, aligned with CORDIC sin/cos output.
REQ-013 valid_dly  output  1  angle_valid delayed DELAY cycles.

Function
REQ-014 Phase accumulator acc SHALL be 24 bits, units 1/32768 degree, modulo WRAP = 11796480 (360 degrees).
REQ-015 On an edge with tick=1 and sync=0, acc SHALL become acc+inc, minus WRAP if the sum is >= WRAP; single subtraction suffices since inc < WRAP.
REQ-016 On an edge with sync=1, acc SHALL become 0 regardless of tick; no angle_valid pulse for that edge.
REQ-017 inc_load=1 SHALL write a shadow register; the active increment SHALL update from the shadow at the next edge where tick=1, after that tick's step (same-edge tick uses the old increment).
REQ-018 Repeated inc_load before a tick SHALL keep only the last value.
REQ-019 Phase p = new acc[23:8] (0..46079, units 1/128 degree) SHALL fold as: p < 11520 -> angle = p, cos_neg=0; 11520 <= p < 34560 -> angle = 23040-p, cos_neg=1; p >= 34560 -> angle = p-46080, cos_neg=0.
REQ-020 angle, cos_neg SHALL be registered from the new phase at the same edge acc steps; angle_valid SHALL be high exactly the cycle after a tick-step edge (latency 1).
REQ-021 tick held high on consecutive cycles SHALL step every cycle, angle_valid high every cycle.
REQ-022 cos_neg_dly and valid_dly SHALL be a DELAY-stage shift register clocked every cycle, independent of tick.
REQ-023 Fold arithmetic SHALL be 17-bit signed internally; no output saturation is required since fold range fits 16 bits.

Reset
REQ-024 On reset=1: acc=0, active and shadow increment=INC_RESET, angle=0, angle_valid=0, cos_neg=0, all delay stages=0.
REQ-025 Reset SHALL override tick, sync, inc_load on the same edge; reset mid-stream SHALL drop in-flight delay-line contents.

Configuration
REQ-026 Macro LFO_ZERO_ANGLE_GUARD_EN: when defined, folded angle 0 SHALL be output as 16'h0001 (downstream zeroes its outputs on input 0); when undefined, angle 0 SHALL pass unchanged.

Verification
REQ-027 Reset, inc_load 16'h8000, one tick -> angle=16'h0080, cos_neg=0, angle_valid 1 cycle, valid_dly high DELAY cycles later.
REQ-028 inc 16'h8000, 90 ticks -> angle=16'h2D00, cos_neg=1; 270 ticks -> angle=16'hD300, cos_neg=0.
REQ-029 inc 16'h8000, 180 and 360 ticks -> angle=16'h0001 with LFO_ZERO_ANGLE_GUARD_EN, 16'h0000 without; acc wraps to 0 at 360.
REQ-030 sync and tick same edge after 10 ticks -> acc=0, no angle_valid; next tick -> angle=16'h0080.
REQ-031 inc_load 16'h4000 same edge as tick with active 16'h8000 -> that step +1 degree, following step +0.5 degree (angle +64).
REQ-032 reset asserted with valid_dly pipeline half full -> cos_neg_dly, valid_dly low next cycle and stay low until a new tick propagates.
